// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter with burst locking. It shares the single write port of
// an asynchronous FIFO between NUM_REQ valid/ready requesters in the write clock domain.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         wclk,
  input  logic                         wrst,
  input  logic [NUM_REQ-1:0]           req_en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         full,
  output logic                         wr,
  output logic [DATAWIDTH-1:0]         wdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         grant_vld,
  output logic                         busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST);
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e               state, state_nxt;
  logic [IDW-1:0]       rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]       owner, owner_nxt;
  logic [CW-1:0]        beat_cnt, beat_cnt_nxt;
  logic [NUM_REQ-1:0]   elig;
  logic [IDW-1:0]       sel;
  logic [IDW-1:0]       gid;
  logic                 gvld;
  logic                 xfer;
  logic [DATAWIDTH-1:0] data_arr [NUM_REQ];

  // Increment modulo NUM_REQ. NUM_REQ need not be a power of two.
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  assign elig = req_valid & req_en;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATAWIDTH +: DATAWIDTH];
  end

  // Scan from rr_ptr with wrap-around. The first eligible index wins.
  always_comb begin : sel_scan
    logic [IDW-1:0] idx;
    logic           found;
    // NOTE: every always_comb output gets a default value before any branch.
    // A path that leaves a signal unassigned would infer a latch.
    sel   = rr_ptr;
    found = 1'b0;
    idx   = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
  end

  always_comb begin
    gid  = sel;
    gvld = |elig;
    if (state == BURST) begin
      gid  = owner;
      gvld = elig[owner];
    end
    // Reset gates the handshake. Otherwise a live requester would be granted while the flops are held.
    xfer = gvld & ~full & wrst;
  end

  assign wr        = xfer;
  assign wdata     = data_arr[gid];
  assign grant_id  = gid;
  assign grant_vld = gvld & wrst;
  assign busy      = (state == BURST) & wrst;
  assign req_ready = xfer ? (NUM_REQ'(1) << gid) : '0;

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            rr_ptr_nxt = next_idx(sel);
          end else begin
            state_nxt    = BURST;
            owner_nxt    = sel;
            beat_cnt_nxt = CW'(1);
          end
        end
      end
      BURST: begin
        if (xfer) begin
          if (beat_cnt + 1'b1 == LAST_BEAT) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = next_idx(owner);
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end else if (!elig[owner]) begin
          // The owner went away. Hand its turn on and spend one bubble cycle.
          state_nxt    = IDLE;
          rr_ptr_nxt   = next_idx(owner);
          beat_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All flops then sample
  // pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of the asynchronous FIFO between NUM_REQ requesters in the write-clock domain.
- Each requester uses a valid/ready handshake.
- The winner's data is steered onto the FIFO wr/wdata inputs, gated by the FIFO full flag.
- Burst locking keeps one requester on the port for up to MAX_BURST consecutive beats, to preserve packet locality.
- A per-requester enable mask lets software configure which sources may write.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
DATAWIDTH, 8, data width; must match the FIFO DATAWIDTH.
MAX_BURST, 4, maximum consecutive beats per grant (>=1); 1 means pure per-beat round-robin.

Ports:
wclk  input  1  write-domain clock; all state on rising edge.
wrst  input  1  asynchronous, active-low reset.
req_en  input  NUM_REQ  per-requester enable mask; a disabled requester is never granted.
req_valid  input  NUM_REQ  requester i has a beat.
req_data  input  NUM_REQ*DATAWIDTH  packed data; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
req_ready  output  NUM_REQ  one-hot; beat i transfers this cycle when req_valid[i] & req_ready[i].
full  input  1  FIFO full flag (write domain).
wr  output  1  FIFO write enable.
wdata  output  DATAWIDTH  FIFO write data.
grant_id  output  $clog2(NUM_REQ)  index of the current grant holder; valid when grant_vld=1.
grant_vld  output  1  a grant exists this cycle (may be stalled by full).
busy  output  1  state is BURST.

Behaviour:
State registers:
- state: IDLE or BURST.
- rr_ptr: highest-priority index.
- owner: locked requester.
- beat_cnt: width $clog2(MAX_BURST+1).

Reset (wrst=0, asynchronous):
- state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
- wr, req_ready, grant_vld and busy are forced to 0 while reset is asserted. wdata is don't-care.

Eligibility:
- elig[i] = req_valid[i] & req_en[i].

IDLE:
- sel = first eligible index scanning rr_ptr, rr_ptr+1, ... with wrap-around modulo NUM_REQ (NUM_REQ need not be a power of two).
- grant_vld = |elig and grant_id = sel, both combinational.
- A transfer occurs when grant_vld & ~full. On a transfer: wr=1, wdata=req_data[sel], req_ready[sel]=1.
- Transfer with MAX_BURST=1: rr_ptr <= (sel+1) mod NUM_REQ; stay IDLE.
- Transfer with MAX_BURST>1: owner <= sel, beat_cnt <= 1, state <= BURST; rr_ptr unchanged.
- full=1: no transfer, no state change, all ready=0; grant_vld and grant_id still reflect sel.

BURST:
- grant_id = owner; grant_vld = elig[owner]; busy=1.
- Case elig[owner] & ~full: transfer from owner and beat_cnt <= beat_cnt+1. If beat_cnt+1 == MAX_BURST: state <= IDLE, rr_ptr <= (owner+1) mod NUM_REQ, beat_cnt <= 0.
- Case elig[owner] & full: stall. No transfer, beat_cnt unchanged, lock held.
- Case ~elig[owner] (valid dropped or enable cleared): release. No transfer this cycle, state <= IDLE, rr_ptr <= (owner+1) mod NUM_REQ, beat_cnt <= 0. The release costs exactly one bubble cycle.

Latency and handshake rules:
- Write path is combinational: zero-cycle latency from req_valid to wr.
- wr is never asserted when full=1.
- req_ready is at most one-hot.
- req_ready may be asserted only while the corresponding req_valid is high.

Other rules:
- A requester that never holds valid does not consume its turn.
- Fairness: every continuously eligible requester is served within (NUM_REQ-1)*MAX_BURST beats of other traffic.
- req_en changes take effect the same cycle.
- Reset mid-burst aborts the burst with no partial state retained; the first grant after reset starts from index 0.

Test Plan:
1. Reset, then all 4 requesters hold valid with req_en=4'hF, MAX_BURST=1, full=0 -> grant_id sequence 0,1,2,3,0,... with wr=1 every cycle and wdata matching each source's data.
2. MAX_BURST=4, requesters 0 and 2 always valid -> 4 beats from 0, 4 beats from 2, then 0 again; busy=1 during each burst; no bubble between bursts.
3. Requester 1 drops valid after 2 beats of a burst -> one cycle with wr=0 and busy=1, then IDLE; the next grant goes to requester 2 (or the next eligible after it).
4. full=1 for 3 cycles mid-burst -> wr=0, req_ready=0 and beat_cnt frozen during the stall; the burst resumes and totals exactly MAX_BURST beats.
5. req_en=4'b1011 with all valid -> requester 2 is never granted; rotation is 0,1,3,0. Clearing req_en[owner] mid-burst -> release on the same cycle.
6. Assert wrst mid-burst on a non-clock edge -> wr, req_ready and busy drop immediately. After release, the first grant is requester 0, even if rr_ptr was 3 before reset.
